demod_rx_ctrl: RTL and testbench

Receive-side controller that sequences the 2-bit-per-symbol correlation demodulator. On start it holds the demodulator in reset, releases it, then waits for frame-header sync and its valid output. It then assembles the serial bit stream into a length-prefixed, checksummed frame and reports bytes, completion and error status. Sits between the demodulator and the packet/UART layer, all in the clk_fast domain.

---
 rtl/demod_rx_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_demod_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_rx_ctrl.sv
`timescale 1ns/1ps
// demod_rx_ctrl
// Receive-side sequencer for the 2-bit-per-symbol correlation demodulator.
// Holds the demodulator in reset after a start request, waits for header
// sync (demod_valid), then assembles MSB-first serial bits into a frame:
// length byte L, L payload bytes, checksum byte (8-bit wrapping sum).
//
// Ports (all in clk_fast domain, rst async active-low):
//   start        in   request one frame, honoured in IDLE only
//   abort        in   cancel the current receive (error code 5)
//   demod_valid  in   demodulator output valid (level)
//   bit_stb      in   one pulse per demodulated bit
//   bit_in       in   demodulated bit, qualified by bit_stb
//   demod_rst_n  out  active-low demodulator reset
//   busy         out  high outside IDLE
//   byte_out     out  last payload byte (held between strobes)
//   byte_valid   out  one-cycle strobe for byte_out
//   frame_len    out  length field of current/last frame
//   frame_done   out  one-cycle pulse, frame good
//   frame_err    out  one-cycle pulse, frame failed
//   err_code     out  0 none,1 sync to,2 bit to,3 bad len,4 csum,5 abort
module demod_rx_ctrl #(
    parameter int ARM_CYCLES   = 16,
    parameter int SYNC_TIMEOUT = 2000000,
    parameter int BIT_TIMEOUT  = 4096,
    parameter int MAX_LEN      = 64
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       demod_valid,
    input  logic       bit_stb,
    input  logic       bit_in,
    output logic       demod_rst_n,
    output logic       busy,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       frame_err,
    output logic [2:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_SYNC, S_LEN, S_PAYLOAD, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_SYNC  = 3'd1;
    localparam logic [2:0] E_BIT   = 3'd2;
    localparam logic [2:0] E_LEN   = 3'd3;
    localparam logic [2:0] E_CSUM  = 3'd4;
    localparam logic [2:0] E_ABORT = 3'd5;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;      // shared by arm, sync and bit timers
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  frame_len_q, frame_len_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        frame_done_q, frame_done_d;

    logic        accept;
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic        rx_state;

    assign accept    = bit_stb & demod_valid;
    assign rx_byte   = {shreg_q[6:0], bit_in};
    assign byte_done = accept && (bit_cnt_q == 3'd7);
    assign rx_state  = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                       (state_q == S_CHECK);

    // State register
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            csum_q       <= '0;
            byte_cnt_q   <= '0;
            frame_len_q  <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            err_code_q   <= E_NONE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            csum_q       <= csum_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_len_q  <= frame_len_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            err_code_q   <= err_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        csum_d       = csum_q;
        byte_cnt_d   = byte_cnt_q;
        frame_len_d  = frame_len_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        err_code_d   = err_code_q;
        // Registered off DONE so the pulse lands two cycles after the
        // final checksum strobe.
        frame_done_d = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_ARM;
                    timer_d     = '0;
                    err_code_d  = E_NONE;
                    frame_len_d = '0;
                    csum_d      = '0;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    shreg_d     = '0;
                end
            end
            S_ARM: begin
                if (timer_q == 32'(ARM_CYCLES - 1)) begin
                    state_d = S_WAIT_SYNC;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WAIT_SYNC: begin
                if (demod_valid) begin
                    state_d = S_LEN;
                    timer_d = '0;
                end else if (timer_q == 32'(SYNC_TIMEOUT - 1)) begin
                    state_d    = S_ERR;
                    err_code_d = E_SYNC;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_LEN, S_PAYLOAD, S_CHECK: begin
                // A dropped demod_valid just stalls acceptance; the bit
                // timer is what eventually reports it.
                if (accept) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    timer_d   = '0;
                end else if (timer_q == 32'(BIT_TIMEOUT - 1)) begin
                    state_d    = S_ERR;
                    err_code_d = E_BIT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end

                if (byte_done) begin
                    if (state_q == S_LEN) begin
                        frame_len_d = rx_byte;
                        byte_cnt_d  = '0;
                        if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
                            state_d    = S_ERR;
                            err_code_d = E_LEN;
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        byte_out_d   = rx_byte;
                        byte_valid_d = 1'b1;
                        csum_d       = csum_q + rx_byte;
                        byte_cnt_d   = byte_cnt_q + 8'd1;
                        if (byte_cnt_q == frame_len_q - 8'd1)
                            state_d = S_CHECK;
                    end else begin
                        if (rx_byte == csum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_ERR;
                            err_code_d = E_CSUM;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort outranks everything, including a byte completing this cycle.
        if (abort && (state_q == S_ARM || state_q == S_WAIT_SYNC || rx_state)) begin
            state_d      = S_ERR;
            err_code_d   = E_ABORT;
            byte_valid_d = 1'b0;
            byte_out_d   = byte_out_q;
            csum_d       = csum_q;
        end
    end

    // Outputs
    always_comb begin
        demod_rst_n = 1'b1;
        busy        = 1'b1;
        frame_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                demod_rst_n = 1'b0;
                busy        = 1'b0;
            end
            S_ARM:   demod_rst_n = 1'b0;
            S_ERR:   frame_err   = 1'b1;
            default: ;
        endcase
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_len  = frame_len_q;
    assign frame_done = frame_done_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_demod_rx_ctrl.sv
`timescale 1ns/1ps
module tb_demod_rx_ctrl;

    localparam int ARM_C   = 16;
    localparam int SYNC_TO = 500;
    localparam int BIT_TO  = 300;
    localparam int MAX_L   = 64;

    logic       clk_fast = 1'b0;
    logic       rst, start, abort, demod_valid, bit_stb, bit_in;
    logic       demod_rst_n, busy, byte_valid, frame_done, frame_err;
    logic [7:0] byte_out, frame_len;
    logic [2:0] err_code;

    demod_rx_ctrl #(
        .ARM_CYCLES(ARM_C), .SYNC_TIMEOUT(SYNC_TO),
        .BIT_TIMEOUT(BIT_TO), .MAX_LEN(MAX_L)
    ) dut (
        .clk_fast(clk_fast), .rst(rst), .start(start), .abort(abort),
        .demod_valid(demod_valid), .bit_stb(bit_stb), .bit_in(bit_in),
        .demod_rst_n(demod_rst_n), .busy(busy), .byte_out(byte_out),
        .byte_valid(byte_valid), .frame_len(frame_len),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic [7:0] len;
        logic [7:0] seed;
        logic [7:0] step;
        logic       bad_csum;
        int         spacing;
        int         abort_byte;
        logic       mid_start;
        logic       exp_done;
        logic [2:0] exp_code;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_q[$];
    int nvec = 0, nmis = 0;
    int cyc = 0, stb_cyc = 0, done_cyc = -1, err_cyc = -1;
    int done_cnt = 0, err_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // Advance one clock and sample outputs; scoreboard pops here.
    task automatic tick();
        logic [7:0] eb;
        @(posedge clk_fast);
        #1;
        cyc++;
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL byte_valid: got strobe with %02h, expected none", byte_out);
            end else begin
                eb = exp_q.pop_front();
                check("byte_out", 32'(byte_out), 32'(eb));
                check("byte_lat", 32'(cyc - stb_cyc), 32'd1);
            end
        end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_err)  begin err_cnt++;  err_cyc  = cyc; end
    endtask

    task automatic send_bit(input logic b, input int sp);
        bit_in  = b;
        bit_stb = 1'b1;
        stb_cyc = cyc;
        tick();
        bit_stb = 1'b0;
        for (int i = 1; i < sp; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input int sp);
        for (int i = 7; i >= 0; i--) send_bit(v[i], sp);
    endtask

    // Pulse start, measure demod_rst_n low time; returns WAIT_SYNC entry cycle.
    task automatic do_arm(output int wc);
        int lowcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (demod_rst_n == 1'b0 && lowcnt < 40) begin
            lowcnt++;
            tick();
        end
        check("arm_len", 32'(lowcnt), 32'(ARM_C));
        check("arm_busy", 32'(busy), 32'd1);
        wc = cyc;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (done_cnt + err_cnt == 0 && n < bound) begin
            tick();
            n++;
        end
        if (done_cnt + err_cnt == 0) begin
            nvec++; nmis++;
            $display("FAIL end_wait: got no frame_done/frame_err, expected one within %0d cycles", bound);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] b, cs;
        int wc;
        logic aborted = 1'b0;
        done_cnt = 0; err_cnt = 0; done_cyc = -1;
        do_arm(wc);
        repeat (100) tick();
        demod_valid = 1'b1;
        tick();
        send_byte(v.len, v.spacing);
        if (v.len != 8'd0 && int'(v.len) <= MAX_L) begin
            b = v.seed; cs = 8'd0;
            for (int k = 0; k < int'(v.len) && !aborted; k++) begin
                if (k == v.abort_byte) begin
                    for (int i = 7; i >= 1; i--) send_bit(b[i], v.spacing);
                    bit_in = b[0]; bit_stb = 1'b1; abort = 1'b1;
                    stb_cyc = cyc;
                    tick();
                    bit_stb = 1'b0; abort = 1'b0;
                    aborted = 1'b1;
                end else begin
                    exp_q.push_back(b);
                    cs = 8'(cs + b);
                    send_byte(b, v.spacing);
                    if (v.mid_start && k == 0) begin
                        start = 1'b1; tick(); start = 1'b0;
                    end
                end
                b = 8'(b + v.step);
            end
            if (!aborted) send_byte(v.bad_csum ? 8'(cs + 8'd1) : cs, v.spacing);
        end
        wait_end(40);
        repeat (3) tick();
        check("done_cnt", 32'(done_cnt), 32'(v.exp_done));
        check("err_cnt", 32'(err_cnt), 32'(!v.exp_done));
        check("err_code", 32'(err_code), 32'(v.exp_code));
        check("frame_len", 32'(frame_len), 32'(v.len));
        check("busy_end", 32'(busy), 32'd0);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        if (v.exp_done) check("done_lat", 32'(done_cyc - stb_cyc), 32'd2);
        demod_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_demod_rst_n"}, 32'(demod_rst_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        int wc, n;
        //        len     seed   step   bad   sp  abt mid  done code
        vecs[0] = '{8'd3,  8'h12, 8'h22, 1'b0, 64, -1, 1'b0, 1'b1, 3'd0};
        vecs[1] = '{8'd2,  8'hF0, 8'h30, 1'b0, 6,  -1, 1'b0, 1'b1, 3'd0};
        vecs[2] = '{8'd2,  8'hF0, 8'h30, 1'b1, 6,  -1, 1'b0, 1'b0, 3'd4};
        vecs[3] = '{8'd0,  8'h00, 8'h00, 1'b0, 4,  -1, 1'b0, 1'b0, 3'd3};
        vecs[4] = '{8'd65, 8'h00, 8'h00, 1'b0, 4,  -1, 1'b0, 1'b0, 3'd3};
        vecs[5] = '{8'd64, 8'h01, 8'h03, 1'b0, 3,  -1, 1'b0, 1'b1, 3'd0};
        vecs[6] = '{8'd4,  8'hA5, 8'h11, 1'b0, 5,  -1, 1'b1, 1'b1, 3'd0};
        vecs[7] = '{8'd3,  8'h10, 8'h20, 1'b0, 5,  1,  1'b0, 1'b0, 3'd5};
        vecs[8] = '{8'd1,  8'hFF, 8'h00, 1'b0, 2,  -1, 1'b0, 1'b1, 3'd0};

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        demod_valid = 1'b0; bit_stb = 1'b0; bit_in = 1'b0;
        repeat (3) @(posedge clk_fast);
        #1;
        check_reset_outs("rst");
        rst = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Sync timeout: frame_err lands SYNC_TO cycles after WAIT_SYNC entry.
        done_cnt = 0; err_cnt = 0; err_cyc = -1;
        do_arm(wc);
        n = 0;
        while (err_cnt == 0 && n < SYNC_TO + 20) begin tick(); n++; end
        check("sync_to_lat", 32'(err_cyc - wc), 32'(SYNC_TO));
        check("sync_to_code", 32'(err_code), 32'd1);
        repeat (3) tick();
        check("sync_to_cnt", 32'(err_cnt), 32'd1);

        // Bit timeout mid-payload.
        done_cnt = 0; err_cnt = 0; err_cyc = -1;
        do_arm(wc);
        repeat (20) tick();
        demod_valid = 1'b1;
        tick();
        send_byte(8'd3, 4);
        exp_q.push_back(8'h77);
        send_byte(8'h77, 4);
        send_bit(1'b1, 4); send_bit(1'b0, 4); send_bit(1'b0, 4);
        n = 0;
        while (err_cnt == 0 && n < BIT_TO + 20) begin tick(); n++; end
        check("bit_to_lat", 32'(err_cyc - stb_cyc), 32'(BIT_TO + 1));
        check("bit_to_code", 32'(err_code), 32'd2);
        check("bit_to_bytes", 32'(exp_q.size()), 32'd0);
        demod_valid = 1'b0;
        exp_q.delete();
        repeat (3) tick();

        // start+abort together in IDLE: ignored, err_code not cleared.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_demod_rst_n", 32'(demod_rst_n), 32'd0);
        check("sa_err_code", 32'(err_code), 32'd2);

        // Reset mid-frame.
        do_arm(wc);
        repeat (10) tick();
        demod_valid = 1'b1;
        tick();
        send_byte(8'd5, 3);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 3);
        send_bit(1'b1, 3); send_bit(1'b1, 3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outs("midrst");
        exp_q.delete();
        done_cnt = 0; err_cnt = 0;
        repeat (3) tick();
        rst = 1'b1;
        demod_valid = 1'b0;
        repeat (5) tick();
        check("midrst_done", 32'(done_cnt), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
